pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch/decode/execute control FSM that drives the program_counter. It reads `count`, fetches 16-bit instructions over a ready handshake, and decodes them. It issues `LoadPC`/`IncPC`/`new_count` back to the program counter, and ALU/accumulator strobes to the datapath. It is the master end of the program_counter control interface.

Parameters:
ADDR_WIDTH, 8, width of count/new_count/mem_addr/operand
INSTR_WIDTH, 16, instruction word width; opcode = instr[15:12], operand = instr[7:0]

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
run  input  1  level; 1 = execute program, 0 = stop at next instruction boundary
count  input  ADDR_WIDTH  current PC from program_counter
instr  input  INSTR_WIDTH  instruction memory read data, valid when mem_ready=1
mem_ready  input  1  instruction memory read data valid
zero  input  1  datapath accumulator-zero flag
mem_req  output  1  instruction read request
mem_addr  output  ADDR_WIDTH  read address (= count)
LoadPC  output  1  load new_count into PC (1-cycle pulse)
IncPC  output  1  increment PC (1-cycle pulse)
new_count  output  ADDR_WIDTH  jump target (= IR[7:0])
alu_op  output  3  0 PASS, 1 ADD, 2 SUB, 3 AND
acc_load  output  1  accumulator write strobe (1-cycle pulse)
operand  output  ADDR_WIDTH  immediate (= IR[7:0])
halted  output  1  sticky halt flag
illegal  output  1  sticky illegal-opcode flag

Behaviour:
- reset is sampled on the rising clk edge. When it is low: state=IDLE, IR=16'h0000, halted=0, illegal=0. All outputs read 0 in the following cycle. Reset overrides everything, including mid-fetch (`mem_req` drops next cycle) and HALT.
- States: IDLE, FETCH, DECODE, EXECUTE, HALT.
- IDLE: all strobes 0. If run=1, go to FETCH next cycle.
- FETCH: `mem_req`=1, `mem_addr`=count. Hold while mem_ready=0 (no timeout). On mem_ready=1, latch instr into IR and go to DECODE. A mem_ready that is high outside FETCH is ignored.
- DECODE: 1 cycle, no strobes. Classifies the opcode.
- EXECUTE: 1 cycle. Strobes are decoded combinationally from state and IR:
  - 0 NOP: IncPC.
  - 1 LDI: acc_load, alu_op=PASS, IncPC.
  - 2 ADD / 3 SUB / 4 AND: acc_load, alu_op=1/2/3, IncPC.
  - 5 JMP: LoadPC.
  - 6 JZ: LoadPC if zero=1 sampled this cycle, else IncPC.
  - 7 JNZ: LoadPC if zero=0, else IncPC.
  - F HALT: no PC strobe; go to HALT.
  - 8–E (illegal): no strobes; illegal=1; go to HALT.
- After a non-halting EXECUTE: go to FETCH if run=1, otherwise IDLE.
- HALT: halted=1, all strobes 0, stays in HALT until reset. run is ignored.
- Invariants:
  - LoadPC and IncPC are never both 1.
  - Each is 1 for exactly one cycle per instruction, and only in EXECUTE.
  - acc_load is only asserted in EXECUTE.
- new_count = operand = IR[7:0] at all times; 0 after reset. alu_op = 0 outside EXECUTE.
- IR[11:8] is ignored.
- PC wrap (255→0) is owned by program_counter. The sequencer must not special-case it; a fetch from 8'hFF followed by IncPC yields the next fetch at 8'h00.
- Latency: 3 cycles per instruction with zero-wait memory (FETCH, DECODE, EXECUTE), plus 1 cycle per mem_ready wait.
- Updated count is visible at the next FETCH.
- Dropping run mid-instruction completes the current instruction before IDLE.

Test Plan:
- Reset: reset=0 for 2 cycles with run=1, then release → all outputs 0 during reset. mem_req=1 and mem_addr=count on the 1st cycle after release.
- Straight-line with zero-wait memory: program {LDI 0x05, ADD 0x03, NOP} at 0,1,2 → IncPC pulses every 3rd cycle. acc_load is 1 in the EXECUTE cycles of LDI and ADD only, with alu_op 0 then 1 and operand 0x05 then 0x03. LoadPC is never 1.
- Jumps: JZ 0x40 with zero=1 → LoadPC=1, new_count=0x40, IncPC=0. JNZ 0x40 with zero=1 → IncPC=1, LoadPC=0. JMP 0xFF, then NOP at 0xFF → next mem_addr=0x00.
- Memory wait: hold mem_ready=0 for 4 cycles in FETCH → mem_req held 5 cycles, mem_addr stable, IR unchanged. Latch occurs on the mem_ready=1 cycle.
- Halt/illegal: HALT (0xF000) → halted=1 the cycle after EXECUTE, with no further mem_req despite run=1. Opcode 0x9 → illegal=1, halted=1, no strobes. Both clear only on reset=0.
- Run/reset mid-operation: drop run during DECODE → instruction completes, then IDLE with no mem_req. Assert reset=0 during a FETCH wait → IDLE next cycle, mem_req=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control FSM: master side of the program_counter control
// interface, fetching instruction words over a ready handshake and strobing the datapath.
module pc_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [ADDR_WIDTH-1:0]  count,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   mem_ready,
  input  logic                   zero,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   LoadPC,
  output logic                   IncPC,
  output logic [ADDR_WIDTH-1:0]  new_count,
  output logic [2:0]             alu_op,
  output logic                   acc_load,
  output logic [ADDR_WIDTH-1:0]  operand,
  output logic                   halted,
  output logic                   illegal
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALT} state_e;

  state_e                 state_q;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic                   halted_q, illegal_q;

  logic [3:0] op;
  logic       op_illegal, op_halt;
  logic       unused_ir;

  assign op         = ir_q[INSTR_WIDTH-1 -: 4];
  assign op_halt    = (op == 4'hF);
  assign op_illegal = (op >= 4'h8) && (op <= 4'hE);
  assign unused_ir  = ^ir_q[INSTR_WIDTH-5:ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (run) state_q <= FETCH;
        FETCH:   if (mem_ready) begin
                   ir_q    <= instr;
                   state_q <= DECODE;
                 end
        DECODE:  state_q <= EXECUTE;
        EXECUTE: begin
          if (op_halt || op_illegal) begin
            state_q   <= HALT;
            halted_q  <= 1'b1;
            illegal_q <= op_illegal;
          end else begin
            state_q <= run ? FETCH : IDLE;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  // EXECUTE strobes follow the latched IR and this cycle's zero flag
  always_comb begin
    LoadPC   = 1'b0;
    IncPC    = 1'b0;
    acc_load = 1'b0;
    alu_op   = 3'd0;
    if (state_q == EXECUTE) begin
      case (op)
        4'h0: IncPC = 1'b1;
        4'h1: begin acc_load = 1'b1; IncPC = 1'b1; end
        4'h2: begin acc_load = 1'b1; alu_op = 3'd1; IncPC = 1'b1; end
        4'h3: begin acc_load = 1'b1; alu_op = 3'd2; IncPC = 1'b1; end
        4'h4: begin acc_load = 1'b1; alu_op = 3'd3; IncPC = 1'b1; end
        4'h5: LoadPC = 1'b1;
        4'h6: begin LoadPC = zero;  IncPC = ~zero; end
        4'h7: begin LoadPC = ~zero; IncPC = zero;  end
        default: ;
      endcase
    end
  end

  assign mem_req   = (state_q == FETCH);
  assign mem_addr  = mem_req ? count : '0;
  assign new_count = ir_q[ADDR_WIDTH-1:0];
  assign operand   = ir_q[ADDR_WIDTH-1:0];
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural program counter and
// instruction memory wrapped around it.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, mem_ready, zero;
  logic [7:0]  count;
  logic [15:0] instr;
  logic        mem_req, LoadPC, IncPC, acc_load, halted, illegal;
  logic [7:0]  mem_addr, new_count, operand;
  logic [2:0]  alu_op;

  logic [15:0] mem [256];
  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .count(count), .instr(instr),
    .mem_ready(mem_ready), .zero(zero), .mem_req(mem_req), .mem_addr(mem_addr),
    .LoadPC(LoadPC), .IncPC(IncPC), .new_count(new_count), .alu_op(alu_op),
    .acc_load(acc_load), .operand(operand), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign instr = mem[mem_addr];

  always @(posedge clk) begin
    if (!reset)      count <= 8'h00;
    else if (LoadPC) count <= new_count;
    else if (IncPC)  count <= count + 8'h01;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobe vector {mem_req, LoadPC, IncPC, acc_load, alu_op}
  task automatic chk_strb(input string tag, input logic [6:0] exp);
    chk(tag, {9'd0, mem_req, LoadPC, IncPC, acc_load, alu_op}, {9'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    mem[8'h00] = 16'h1005;
    mem[8'h01] = 16'h2003;
    mem[8'h02] = 16'h0000;
    mem[8'h03] = 16'h6040;
    mem[8'h40] = 16'h7040;
    mem[8'h41] = 16'h50FF;
    mem[8'hFF] = 16'h0000;
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1; zero = 1'b0;

    tick();
    chk_strb("rst1_strb", 7'b0);
    tick();
    chk_strb("rst2_strb", 7'b0);
    chk("rst_addr", {8'd0, mem_addr}, 16'h0000);
    chk("rst_newcount", {8'd0, new_count}, 16'h0000);
    chk("rst_flags", {14'd0, halted, illegal}, 16'h0000);
    reset = 1'b1;

    tick();
    chk_strb("fetch0", 7'b1000_000);
    chk("fetch0_addr", {8'd0, mem_addr}, 16'h0000);
    tick();
    chk_strb("dec_ldi", 7'b0);
    chk("dec_ldi_opnd", {8'd0, operand}, 16'h0005);
    tick();
    chk_strb("ex_ldi", 7'b0011_000);
    chk("ex_ldi_opnd", {8'd0, operand}, 16'h0005);
    tick();
    chk("fetch1_addr", {8'd0, mem_addr}, 16'h0001);
    tick(); tick();
    chk_strb("ex_add", 7'b0011_001);
    chk("ex_add_opnd", {8'd0, operand}, 16'h0003);
    tick(); tick(); tick();
    chk_strb("ex_nop", 7'b0010_000);
    tick();
    chk("fetch3_addr", {8'd0, mem_addr}, 16'h0003);
    tick();
    zero = 1'b1;
    tick();
    chk_strb("ex_jz_taken", 7'b0100_000);
    chk("jz_target", {8'd0, new_count}, 16'h0040);
    tick();
    chk("fetch40_addr", {8'd0, mem_addr}, 16'h0040);
    tick(); tick();
    chk_strb("ex_jnz_nottaken", 7'b0010_000);
    tick();
    chk("fetch41_addr", {8'd0, mem_addr}, 16'h0041);
    zero = 1'b0;
    tick(); tick();
    chk_strb("ex_jmp", 7'b0100_000);
    chk("jmp_target", {8'd0, new_count}, 16'h00FF);
    tick();
    chk("fetchFF_addr", {8'd0, mem_addr}, 16'h00FF);
    tick(); tick();
    chk_strb("ex_nop_ff", 7'b0010_000);
    tick();
    chk("wrap_addr", {8'd0, mem_addr}, 16'h0000);

    // four wait cycles in FETCH, ready on the fifth
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_strb("wait_req", 7'b1000_000);
      chk("wait_addr", {8'd0, mem_addr}, 16'h0000);
      chk("wait_ir", {8'd0, operand}, 16'h0000);
      tick();
    end
    mem_ready = 1'b1;
    chk_strb("wait_req5", 7'b1000_000);
    tick();
    chk_strb("wait_dec", 7'b0);
    chk("wait_latch", {8'd0, operand}, 16'h0005);
    tick();
    chk_strb("wait_ex", 7'b0011_000);

    tick();
    chk("fetch1b_addr", {8'd0, mem_addr}, 16'h0001);
    tick();
    run = 1'b0;
    tick();
    chk_strb("stop_ex", 7'b0011_001);
    tick();
    chk_strb("stop_idle1", 7'b0);
    tick();
    chk_strb("stop_idle2", 7'b0);

    mem[8'h02] = 16'hF000;
    run = 1'b1;
    tick();
    chk("fetch2_addr", {8'd0, mem_addr}, 16'h0002);
    tick(); tick();
    chk_strb("ex_halt", 7'b0);
    chk("ex_halt_flag", {15'd0, halted}, 16'h0000);
    tick();
    chk("halted", {14'd0, halted, illegal}, 16'h0002);
    chk_strb("halt_noreq1", 7'b0);
    tick(); tick();
    chk_strb("halt_noreq2", 7'b0);
    chk("halt_sticky", {15'd0, halted}, 16'h0001);

    reset = 1'b0;
    tick();
    chk("halt_clr", {14'd0, halted, illegal}, 16'h0000);
    mem[8'h00] = 16'h9012;
    reset = 1'b1;
    tick();
    chk_strb("ill_fetch", 7'b1000_000);
    tick(); tick();
    chk_strb("ex_ill", 7'b0);
    tick();
    chk("ill_flags", {14'd0, halted, illegal}, 16'h0003);
    tick();
    chk_strb("ill_noreq", 7'b0);
    chk("ill_sticky", {14'd0, halted, illegal}, 16'h0003);

    reset = 1'b0;
    tick();
    chk("ill_clr", {14'd0, halted, illegal}, 16'h0000);
    reset = 1'b1; mem_ready = 1'b0;
    tick();
    chk_strb("rstwait_fetch", 7'b1000_000);
    tick();
    chk_strb("rstwait_hold", 7'b1000_000);
    reset = 1'b0;
    tick();
    chk_strb("rstwait_drop", 7'b0);
    chk("rstwait_addr", {8'd0, mem_addr}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
